syndrome_builder: RTL and testbench

- Upstream stage of the GF(2) LSE solver: computes syndrome s = H·e over GF(2) for an N_ERR-bit error/event vector.
- H is streamed in one RANK_MAX-bit column per accepted beat from column storage through a valid/ready handshake.
- After accumulation, a serial popcount produces the syndrome weight and a zero flag, so the controller can skip the solver when the syndrome is trivial.
- The syndrome is presented bit-for-bit to the solver's syndrome input.

---
 rtl/syndrome_builder.sv | 108 ++++++++++
 tb/tb_syndrome_builder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/syndrome_builder.sv
// Syndrome builder: accumulates s = H*e over GF(2) from a column stream of H,
// then counts the set syndrome bits POP_W at a time to give a weight and zero flag.
module syndrome_builder #(
  parameter int RANK_MAX = 936,
  parameter int N_ERR    = 8784,
  parameter int POP_W    = 8,
  localparam int IDX_W   = $clog2(N_ERR),
  localparam int WGT_W   = $clog2(RANK_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_ERR-1:0]    e_in,
  input  logic [RANK_MAX-1:0] col_data,
  input  logic                col_valid,
  output logic                col_ready,
  output logic [IDX_W-1:0]    col_idx,
  output logic [RANK_MAX-1:0] syndrome,
  output logic [WGT_W-1:0]    syn_weight,
  output logic                syn_zero,
  output logic                busy,
  output logic                done
);

  localparam int N_SLICE = RANK_MAX / POP_W;
  localparam int SLC_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, WEIGHT, DONE} state_t;

  state_t           state, state_nxt;
  logic [N_ERR-1:0] e_lat;
  logic [SLC_W-1:0] slice_k;
  logic [POP_W-1:0] cur_slice;
  logic             start_acc;
  logic             xfer;
  logic             last_col;
  logic             last_slice;

  function automatic logic [WGT_W-1:0] popcnt(input logic [POP_W-1:0] v);
    logic [WGT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++) n = n + WGT_W'(v[i]);
    return n;
  endfunction

  assign start_acc  = ((state == IDLE) || (state == DONE)) && start;
  assign col_ready  = (state == ACCUM);
  assign xfer       = col_ready && col_valid;
  assign last_col   = (col_idx == IDX_W'(N_ERR - 1));
  assign last_slice = (slice_k == SLC_W'(N_SLICE - 1));
  assign busy       = (state == ACCUM) || (state == WEIGHT);
  assign done       = (state == DONE);
  assign syn_zero   = done && (syn_weight == '0);

  // Slice selector for the serial popcount; constant part-selects keep index widths exact.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cur_slice = '0;
    for (int k = 0; k < N_SLICE; k++)
      if (slice_k == SLC_W'(k)) cur_slice = syndrome[k*POP_W +: POP_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = ACCUM;
      ACCUM:  if (xfer && last_col) state_nxt = WEIGHT;
      WEIGHT: if (last_slice) state_nxt = DONE;
      DONE:   if (start) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the wide e latch is reset too, so an aborted run leaves no stale error bits behind.
    if (rst) begin
      e_lat      <= '0;
      syndrome   <= '0;
      syn_weight <= '0;
      col_idx    <= '0;
      slice_k    <= '0;
    end else if (start_acc) begin
      e_lat      <= e_in;
      syndrome   <= '0;
      syn_weight <= '0;
      col_idx    <= '0;
      slice_k    <= '0;
    end else if (xfer) begin
      if (e_lat[col_idx]) syndrome <= syndrome ^ col_data;
      if (last_col) begin
        col_idx <= '0;
        slice_k <= '0;
      end else begin
        col_idx <= col_idx + IDX_W'(1);
      end
    end else if (state == WEIGHT) begin
      syn_weight <= syn_weight + popcnt(cur_slice);
      slice_k    <= slice_k + SLC_W'(1);
    end
  end

endmodule

// File: tb/tb_syndrome_builder.sv
// Directed bench for syndrome_builder: a reduced 8x16 instance for function, stalls,
// reset and restart, plus a full-size instance for the weight and latency corner.
module tb_syndrome_builder;

  localparam int RS = 8,   NS = 16,   PS = 4;
  localparam int RB = 936, NB = 8784, PB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // reduced instance
  logic          start_s, col_valid_s, col_ready_s, syn_zero_s, busy_s, done_s;
  logic [NS-1:0] e_in_s;
  logic [RS-1:0] col_data_s, syndrome_s;
  logic [3:0]    col_idx_s;
  logic [3:0]    syn_weight_s;
  bit            ff_mode;

  // full-size instance
  logic          start_b, col_valid_b, col_ready_b, syn_zero_b, busy_b, done_b;
  logic [NB-1:0] e_in_b;
  logic [RB-1:0] col_data_b, syndrome_b;
  logic [13:0]   col_idx_b;
  logic [9:0]    syn_weight_b;

  // Column storage model: column k = k+1, or all ones in ff_mode.
  assign col_data_s = ff_mode ? 8'hFF : ({4'b0, col_idx_s} + 8'd1);
  assign col_data_b = '1;

  syndrome_builder #(.RANK_MAX(RS), .N_ERR(NS), .POP_W(PS)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .e_in(e_in_s), .col_data(col_data_s),
    .col_valid(col_valid_s), .col_ready(col_ready_s), .col_idx(col_idx_s),
    .syndrome(syndrome_s), .syn_weight(syn_weight_s), .syn_zero(syn_zero_s),
    .busy(busy_s), .done(done_s)
  );

  syndrome_builder #(.RANK_MAX(RB), .N_ERR(NB), .POP_W(PB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .e_in(e_in_b), .col_data(col_data_b),
    .col_valid(col_valid_b), .col_ready(col_ready_b), .col_idx(col_idx_b),
    .syndrome(syndrome_b), .syn_weight(syn_weight_b), .syn_zero(syn_zero_b),
    .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One run on the reduced instance; lat counts edges from the start-sampling edge to done.
  task automatic run_small(input logic [NS-1:0] e, input bit stall, input bit poke,
                           output int lat, output int beats, output int stalls,
                           output int frozen_bad);
    int         p;
    bit         gap;
    logic [3:0] idx_before;
    lat = 0; beats = 0; stalls = 0; frozen_bad = 0; p = 0;
    @(negedge clk);
    e_in_s = e; start_s = 1'b1; col_valid_s = 1'b0;
    @(posedge clk); lat = 1;
    @(negedge clk);
    start_s = 1'b0;
    e_in_s  = 16'h3C3C;
    check("start_edge", {62'b0, done_s, busy_s}, 64'h1);
    while (!done_s && lat < 200) begin
      col_valid_s = stall ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
      p++;
      start_s = poke;
      if (poke) e_in_s = 16'hFFFF;
      gap        = col_ready_s && !col_valid_s;
      idx_before = col_idx_s;
      if (col_ready_s && col_valid_s) beats++;
      if (gap) stalls++;
      @(posedge clk); lat++;
      @(negedge clk);
      start_s = 1'b0;
      if (gap && col_idx_s != idx_before) frozen_bad++;
    end
    col_valid_s = 1'b0;
    if (!done_s) check("small_timeout", 64'(done_s), 64'h1);
  endtask

  int lat, beats, stalls, frozen_bad;

  initial begin
    rst = 1'b1; ff_mode = 1'b0;
    start_s = 1'b0; e_in_s = '0; col_valid_s = 1'b0;
    start_b = 1'b0; e_in_b = '0; col_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_syndrome", 64'(syndrome_s), 64'h0);
    check("rst_flags", {59'b0, col_ready_s, syn_zero_s, busy_s, done_s, 1'b0}, 64'h0);
    check("rst_weight_idx", {56'b0, syn_weight_s, col_idx_s}, 64'h0);
    check("rst_big_flags", {60'b0, col_ready_b, syn_zero_b, busy_b, done_b}, 64'h0);
    rst = 1'b0;

    // Basic run: e bits 0 and 2 -> 0x01 ^ 0x03.
    run_small(16'h0005, 1'b0, 1'b0, lat, beats, stalls, frozen_bad);
    check("e5_syndrome", 64'(syndrome_s), 64'h02);
    check("e5_weight", 64'(syn_weight_s), 64'd1);
    check("e5_zero", 64'(syn_zero_s), 64'h0);
    check("e5_latency", 64'(lat), 64'd19);
    check("e5_beats", 64'(beats), 64'd16);

    // All-zero e: still 16 beats, constant timing.
    run_small(16'h0000, 1'b0, 1'b0, lat, beats, stalls, frozen_bad);
    check("e0_syndrome", 64'(syndrome_s), 64'h00);
    check("e0_weight", 64'(syn_weight_s), 64'd0);
    check("e0_zero", 64'(syn_zero_s), 64'h1);
    check("e0_beats", 64'(beats), 64'd16);
    check("e0_col_idx", 64'(col_idx_s), 64'h0);
    check("e0_latency", 64'(lat), 64'd19);

    // Stalled source: valid pattern 1,0,0,1.
    run_small(16'h0005, 1'b1, 1'b0, lat, beats, stalls, frozen_bad);
    check("stall_syndrome", 64'(syndrome_s), 64'h02);
    check("stall_weight", 64'(syn_weight_s), 64'd1);
    check("stall_beats", 64'(beats), 64'd16);
    check("stall_frozen", 64'(frozen_bad), 64'd0);
    check("stall_latency", 64'(lat), 64'(19 + stalls));
    check("stall_count", 64'(stalls > 0), 64'h1);

    // Abort at column 9 with an asynchronous reset.
    @(negedge clk);
    e_in_s = 16'h0005; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0; col_valid_s = 1'b1;
    for (int i = 0; i < 40 && col_idx_s != 4'd9; i++) @(negedge clk);
    check("abort_reached_9", 64'(col_idx_s), 64'd9);
    rst = 1'b1;
    #1;
    check("abort_async_flags", {61'b0, col_ready_s, busy_s, done_s}, 64'h0);
    check("abort_async_idx", 64'(col_idx_s), 64'h0);
    check("abort_async_syn", 64'(syndrome_s), 64'h0);
    @(negedge clk);
    rst = 1'b0; col_valid_s = 1'b0; ff_mode = 1'b1;
    run_small(16'hFFFF, 1'b0, 1'b0, lat, beats, stalls, frozen_bad);
    check("ff_syndrome", 64'(syndrome_s), 64'h00);
    check("ff_weight", 64'(syn_weight_s), 64'd0);
    check("ff_zero", 64'(syn_zero_s), 64'h1);
    check("ff_latency", 64'(lat), 64'd19);
    ff_mode = 1'b0;

    // start held (with a new e) throughout ACCUM and WEIGHT must be ignored.
    run_small(16'h0005, 1'b0, 1'b1, lat, beats, stalls, frozen_bad);
    check("poke_syndrome", 64'(syndrome_s), 64'h02);
    check("poke_weight", 64'(syn_weight_s), 64'd1);
    check("poke_latency", 64'(lat), 64'd19);

    // Restart from DONE: done drops on the start edge (checked inside), column 15 = 0x10.
    run_small(16'h8000, 1'b0, 1'b0, lat, beats, stalls, frozen_bad);
    check("e8000_syndrome", 64'(syndrome_s), 64'h10);
    check("e8000_weight", 64'(syn_weight_s), 64'd1);
    check("e8000_done", 64'(done_s), 64'h1);

    // Full-size corner: only bit 8783 set, all-ones columns.
    @(negedge clk);
    e_in_b = '0; e_in_b[NB-1] = 1'b1; start_b = 1'b1;
    lat = 0;
    @(posedge clk); lat = 1;
    @(negedge clk);
    start_b = 1'b0; e_in_b = '0; col_valid_b = 1'b1;
    while (!done_b && lat < 10000) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    col_valid_b = 1'b0;
    check("big_done", 64'(done_b), 64'h1);
    check("big_latency", 64'(lat), 64'd8902);
    check("big_syn_all1", 64'(&syndrome_b), 64'h1);
    check("big_weight", 64'(syn_weight_b), 64'd936);
    check("big_zero", 64'(syn_zero_b), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
